// File: rtl/spi_register_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_register_bank_pkg
// Purpose  : Shared command-field positions, FSM states and idle TX value.
// Revision : 1.0 - initial release
// ============================================================================
package spi_register_bank_pkg;

   localparam int         CMD_WRITE_BIT = 7;
   localparam logic [7:0] TX_IDLE       = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CMD   = 2'd1,
      ST_WRITE = 2'd2,
      ST_READ  = 2'd3
   } state_e;

endpackage
`default_nettype wire

// File: rtl/spi_cmd_fsm.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_fsm
// Purpose  : Frame/command sequencer with auto-incrementing burst address.
// Revision : 1.0 - initial release
// ============================================================================
module spi_cmd_fsm
   import spi_register_bank_pkg::*;
#(
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_frame_start,
   input  logic              i_byte_valid,
   input  logic              i_cmd_write,
   input  logic [ADDR_W-1:0] i_cmd_addr,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_wr_en,
   output logic              o_rd_load,
   output logic [ADDR_W-1:0] o_rd_addr
);

   state_e            r_state;
   state_e            w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic [ADDR_W-1:0] w_addr_inc;

   assign w_addr_inc = r_addr + ADDR_W'(1);
   assign o_addr     = r_addr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_addr  <= w_addr_nxt;
      end
   end

   // frame_start has priority: a byte arriving with it is discarded.
   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      o_wr_en     = 1'b0;
      o_rd_load   = 1'b0;
      o_rd_addr   = r_addr;
      if (i_frame_start) begin
         w_state_nxt = ST_CMD;
      end else if (i_byte_valid) begin
         case (r_state)
            ST_CMD: begin
               w_addr_nxt  = i_cmd_addr;
               w_state_nxt = i_cmd_write ? ST_WRITE : ST_READ;
               o_rd_load   = ~i_cmd_write;
               o_rd_addr   = i_cmd_addr;
            end
            ST_WRITE: begin
               o_wr_en    = 1'b1;
               w_addr_nxt = w_addr_inc;
            end
            ST_READ: begin
               w_addr_nxt = w_addr_inc;
               o_rd_load  = 1'b1;
               o_rd_addr  = w_addr_inc;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/spi_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : spi_register_bank
// Purpose  : SPI byte-stream register file with burst read/write access.
// Revision : 1.0 - initial release
// ============================================================================
module spi_register_bank
   import spi_register_bank_pkg::*;
#(
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_start,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_in,
   input  logic [7:0]            status_in,
   output logic [7:0]            tx_byte,
   output logic [8*NUM_REGS-1:0] regs_flat,
   output logic                  wr_strobe,
   output logic [ADDR_W-1:0]     wr_addr
);

   localparam logic [ADDR_W-1:0] c_status_addr = ADDR_W'(NUM_REGS - 1);

   logic [ADDR_W-1:0] w_addr;
   logic              w_wr_en;
   logic              w_wr_ok;
   logic              w_rd_load;
   logic [ADDR_W-1:0] w_rd_addr;
   logic [7:0]        w_regs [NUM_REGS];
   logic [7:0]        r_tx_byte;
   logic              r_wr_strobe;
   logic [ADDR_W-1:0] r_wr_addr;

   spi_cmd_fsm #(
      .ADDR_W (ADDR_W)
   ) u_fsm (
      .clk           (clk),
      .rst           (rst),
      .i_frame_start (frame_start),
      .i_byte_valid  (byte_valid),
      .i_cmd_write   (byte_in[CMD_WRITE_BIT]),
      .i_cmd_addr    (byte_in[ADDR_W-1:0]),
      .o_addr        (w_addr),
      .o_wr_en       (w_wr_en),
      .o_rd_load     (w_rd_load),
      .o_rd_addr     (w_rd_addr)
   );

   // The status slot is read-only; the address still advances past it.
   assign w_wr_ok = w_wr_en && (w_addr != c_status_addr);

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi < NUM_REGS - 1) begin : g_rw
         logic [7:0] r_reg;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               r_reg <= '0;
            else if (w_wr_ok && (w_addr == ADDR_W'(gi)))
               r_reg <= byte_in;
         end
         assign w_regs[gi] = r_reg;
      end else begin : g_status
         assign w_regs[gi] = status_in;
      end
      assign regs_flat[8*gi +: 8] = w_regs[gi];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tx_byte   <= TX_IDLE;
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= '0;
      end else begin
         if (frame_start)
            r_tx_byte <= TX_IDLE;
         else if (w_rd_load)
            r_tx_byte <= w_regs[w_rd_addr];
         r_wr_strobe <= w_wr_ok;
         if (w_wr_ok)
            r_wr_addr <= w_addr;
      end
   end

   assign tx_byte   = r_tx_byte;
   assign wr_strobe = r_wr_strobe;
   assign wr_addr   = r_wr_addr;

endmodule
`default_nettype wire

// File: tb/tb_spi_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_register_bank
// Purpose  : Directed, table-driven self-checking bench for spi_register_bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_register_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_start;
   logic        byte_valid;
   logic [7:0]  byte_in;
   logic [7:0]  status_in;
   logic [7:0]  tx_byte;
   logic [63:0] regs_flat;
   logic        wr_strobe;
   logic [2:0]  wr_addr;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       fs;
      logic       bv;
      logic [7:0] b;
      logic [7:0] st;
      logic [7:0] tx;
      logic       ws;
      logic [2:0] wa;
   } vec_t;

   vec_t vecs[$];

   spi_register_bank #(
      .NUM_REGS (8),
      .ADDR_W   (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .byte_valid  (byte_valid),
      .byte_in     (byte_in),
      .status_in   (status_in),
      .tx_byte     (tx_byte),
      .regs_flat   (regs_flat),
      .wr_strobe   (wr_strobe),
      .wr_addr     (wr_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic fs, input logic bv, input logic [7:0] b, input logic [7:0] st,
                      input logic [7:0] tx, input logic ws, input logic [2:0] wa);
      vec_t v;
      v.fs = fs; v.bv = bv; v.b = b; v.st = st; v.tx = tx; v.ws = ws; v.wa = wa;
      vecs.push_back(v);
   endtask

   // Each helper drives on a falling edge and returns on the next falling edge,
   // i.e. with outputs of the capturing rising edge visible.
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      byte_valid = 1'b1;
      byte_in    = b;
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic start_frame();
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst         = 1'b0;
      frame_start = 1'b0;
      byte_valid  = 1'b0;
      byte_in     = 8'h00;
      status_in   = 8'h5A;

      // Write 0x82,11,22 ; read 0x02 ; wrap/status write 0x86,AA,BB,CC ; read 0x07
      add(1, 0, 8'h00, 8'h5A, 8'h00, 0, 3'd0);
      add(0, 1, 8'h82, 8'h5A, 8'h00, 0, 3'd0);
      add(0, 1, 8'h11, 8'h5A, 8'h00, 1, 3'd2);
      add(0, 0, 8'h00, 8'h5A, 8'h00, 0, 3'd0);
      add(0, 1, 8'h22, 8'h5A, 8'h00, 1, 3'd3);
      add(0, 0, 8'h00, 8'h5A, 8'h00, 0, 3'd0);
      add(1, 0, 8'h00, 8'h5A, 8'h00, 0, 3'd0);
      add(0, 1, 8'h02, 8'h5A, 8'h11, 0, 3'd0);
      add(0, 0, 8'h00, 8'h5A, 8'h11, 0, 3'd0);
      add(0, 1, 8'h00, 8'h5A, 8'h22, 0, 3'd0);
      add(0, 1, 8'h00, 8'h5A, 8'h00, 0, 3'd0);
      add(1, 0, 8'h00, 8'h5A, 8'h00, 0, 3'd0);
      add(0, 1, 8'h86, 8'h5A, 8'h00, 0, 3'd0);
      add(0, 1, 8'hAA, 8'h5A, 8'h00, 1, 3'd6);
      add(0, 1, 8'hBB, 8'h5A, 8'h00, 0, 3'd0);
      add(0, 1, 8'hCC, 8'h5A, 8'h00, 1, 3'd0);
      add(1, 0, 8'h00, 8'h5A, 8'h00, 0, 3'd0);
      add(0, 1, 8'h07, 8'h5A, 8'h5A, 0, 3'd0);
      add(0, 1, 8'h00, 8'h5A, 8'hCC, 0, 3'd0);
      add(0, 1, 8'h00, 8'h5A, 8'h00, 0, 3'd0);
      add(1, 0, 8'h00, 8'h5A, 8'h00, 0, 3'd0);
      add(0, 1, 8'h07, 8'h5A, 8'h5A, 0, 3'd0);
      add(0, 0, 8'h00, 8'h3C, 8'h5A, 0, 3'd0);

      repeat (3) @(negedge clk);
      chk("reset_tx", 64'(tx_byte), 64'h00);
      chk("reset_strobe", 64'(wr_strobe), 64'h0);
      chk("reset_wr_addr", 64'(wr_addr), 64'h0);
      chk("reset_regs", regs_flat, 64'h5A00_0000_0000_0000);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         frame_start = vecs[i].fs;
         byte_valid  = vecs[i].bv;
         byte_in     = vecs[i].b;
         status_in   = vecs[i].st;
         @(negedge clk);
         chk($sformatf("vec%0d_tx", i), 64'(tx_byte), 64'(vecs[i].tx));
         chk($sformatf("vec%0d_strobe", i), 64'(wr_strobe), 64'(vecs[i].ws));
         if (vecs[i].ws)
            chk($sformatf("vec%0d_wr_addr", i), 64'(wr_addr), 64'(vecs[i].wa));
         if (i == 5)
            chk("regs_after_write", regs_flat, 64'h5A00_0000_2211_0000);
         if (i == 16)
            chk("regs_after_wrap", regs_flat, 64'h5AAA_0000_2211_00CC);
      end
      frame_start = 1'b0;
      byte_valid  = 1'b0;
      chk("status_live_mirror", regs_flat, 64'h3CAA_0000_2211_00CC);

      // Abort: frame_start mid-burst; following byte must be a command
      start_frame();
      send_byte(8'h81);
      send_byte(8'h33);
      chk("abort_strobe", 64'(wr_strobe), 64'h1);
      chk("abort_wr_addr", 64'(wr_addr), 64'd1);
      start_frame();
      chk("abort_tx_idle", 64'(tx_byte), 64'h00);
      send_byte(8'h02);
      chk("abort_cmd_read_tx", 64'(tx_byte), 64'h11);
      chk("abort_no_strobe", 64'(wr_strobe), 64'h0);
      chk("regs_after_abort", regs_flat, 64'h3CAA_0000_2211_33CC);

      // Preload reg4 so the collision read is observable
      start_frame();
      send_byte(8'h84);
      send_byte(8'h44);
      chk("reg4_strobe_addr", 64'(wr_addr), 64'd4);

      // Collision: frame_start and byte_valid together
      @(negedge clk);
      frame_start = 1'b1;
      byte_valid  = 1'b1;
      byte_in     = 8'h84;
      @(negedge clk);
      frame_start = 1'b0;
      byte_valid  = 1'b0;
      chk("collision_tx", 64'(tx_byte), 64'h00);
      chk("collision_strobe", 64'(wr_strobe), 64'h0);
      send_byte(8'h04);
      chk("collision_read_tx", 64'(tx_byte), 64'h44);
      chk("collision_no_strobe", 64'(wr_strobe), 64'h0);
      chk("regs_after_collision", regs_flat, 64'h3CAA_0044_2211_33CC);

      // Reset mid-burst
      start_frame();
      send_byte(8'h85);
      send_byte(8'h77);
      chk("reg5_strobe", 64'(wr_strobe), 64'h1);
      chk("reg5_value", 64'(regs_flat[47:40]), 64'h77);
      start_frame();
      send_byte(8'h05);
      chk("reg5_read_tx", 64'(tx_byte), 64'h77);
      start_frame();
      send_byte(8'h86);
      @(negedge clk);
      byte_valid = 1'b1;
      byte_in    = 8'h99;
      rst        = 1'b0;
      #1;
      chk("async_rst_tx", 64'(tx_byte), 64'h00);
      chk("async_rst_regs", regs_flat, 64'h3C00_0000_0000_0000);
      @(negedge clk);
      byte_valid = 1'b0;
      chk("rst_strobe_low", 64'(wr_strobe), 64'h0);
      chk("rst_regs_held", regs_flat, 64'h3C00_0000_0000_0000);
      rst = 1'b1;

      // IDLE ignores bytes: 0x83 must not become a write command
      send_byte(8'h83);
      chk("idle_ignore_tx", 64'(tx_byte), 64'h00);
      send_byte(8'h12);
      chk("idle_ignore_strobe", 64'(wr_strobe), 64'h0);
      chk("idle_ignore_regs", regs_flat, 64'h3C00_0000_0000_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
